// File: rtl/br_flow_fork_select_multihot_tracked_if.sv
// Handshake bundle for the tracked multihot-select fork: one push channel,
// NumFlows pop channels and the per-flow served state.
interface br_flow_fork_select_multihot_tracked_if #(
    parameter int unsigned NumFlows = 2,
    parameter int unsigned Width    = 1
);
    logic                      push_ready;
    logic                      push_valid;
    logic [NumFlows-1:0]       push_select_multihot;
    logic [Width-1:0]          push_data;
    logic [NumFlows-1:0]       pop_ready;
    logic [NumFlows-1:0]       pop_valid;
    logic [NumFlows*Width-1:0] pop_data;
    logic [NumFlows-1:0]       served;

    // Environment side: producer plus the per-flow consumers
    modport master (
        input  push_ready,
        output push_valid,
        output push_select_multihot,
        output push_data,
        output pop_ready,
        input  pop_valid,
        input  pop_data,
        input  served
    );

    // Fork side
    modport slave (
        output push_ready,
        input  push_valid,
        input  push_select_multihot,
        input  push_data,
        input  pop_ready,
        output pop_valid,
        output pop_data,
        output served
    );
endinterface

// File: rtl/br_flow_fork_select_multihot_tracked.sv
// Multihot-select fork that broadcasts one payload and tracks per-flow acceptance.
// Optional stall counter: BR_FLOW_FORK_SELECT_MULTIHOT_TRACKED_STALL_CNT_EN.
module br_flow_fork_select_multihot_tracked #(
    parameter int unsigned NumFlows                    = 2,
    parameter int unsigned Width                       = 1,
    parameter int unsigned StallCountWidth             = 16,
    parameter bit          EnableCoverPushBackpressure = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
`ifdef BR_FLOW_FORK_SELECT_MULTIHOT_TRACKED_STALL_CNT_EN
    output logic [StallCountWidth-1:0] stall_count,
`endif
    br_flow_fork_select_multihot_tracked_if.slave bus
);

    logic [NumFlows-1:0] served_q;
    logic [NumFlows-1:0] fire;
    logic [NumFlows-1:0] flow_done;
    logic                push_fire;

    // A flow stops gating the push once unselected, already served, or ready now
    assign bus.pop_valid = {NumFlows{bus.push_valid}} & bus.push_select_multihot & ~served_q;
    assign bus.pop_data  = {NumFlows{bus.push_data}};
    assign fire          = bus.pop_valid & bus.pop_ready;
    assign flow_done     = ~bus.push_select_multihot | served_q | bus.pop_ready;
    assign bus.push_ready = &flow_done;
    assign bus.served    = served_q;
    assign push_fire     = bus.push_valid & bus.push_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            served_q <= '0;
        end else if (push_fire) begin
            served_q <= '0;
        end else begin
            served_q <= served_q | fire;
        end
    end

`ifdef BR_FLOW_FORK_SELECT_MULTIHOT_TRACKED_STALL_CNT_EN
    logic [StallCountWidth-1:0] stall_q;

    // Saturating count of cycles the producer waited
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (bus.push_valid && !bus.push_ready && (stall_q != '1)) begin
            stall_q <= stall_q + StallCountWidth'(1);
        end
    end

    assign stall_count = stall_q;
`endif

`ifndef SYNTHESIS
    param_check_a: assert property (@(posedge clk)
        (NumFlows >= 2) && (Width >= 1) && (StallCountWidth >= 1));

    select_known_a: assert property (@(posedge clk) disable iff (!rst_n)
        bus.push_valid |-> !$isunknown(bus.push_select_multihot));

    select_not_0_when_valid_a: assert property (@(posedge clk) disable iff (!rst_n)
        bus.push_valid |-> (bus.push_select_multihot != '0));

    push_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.push_valid && !bus.push_ready) |=>
            (bus.push_valid && $stable(bus.push_select_multihot) && $stable(bus.push_data)));

    served_subset_a: assert property (@(posedge clk) disable iff (!rst_n)
        bus.push_valid |-> ((served_q & ~bus.push_select_multihot) == '0));

    served_idle_zero_a: assert property (@(posedge clk) disable iff (!rst_n)
        !bus.push_valid |-> (served_q == '0));

    if (EnableCoverPushBackpressure) begin : gen_bp_cover
        push_backpressure_c: cover property (@(posedge clk) disable iff (!rst_n)
            bus.push_valid && !bus.push_ready);
    end else begin : gen_bp_assert
        no_push_backpressure_a: assert property (@(posedge clk) disable iff (!rst_n)
            bus.push_valid |-> bus.push_ready);
    end

    for (genvar i = 0; i < NumFlows; i++) begin : gen_pop_stable
        pop_valid_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
            (bus.pop_valid[i] && !bus.pop_ready[i]) |=> bus.pop_valid[i]);
    end
`endif

endmodule
